// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - 8-digit seven-segment scanner showing the hex word or a BCD-converted counter
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always lit).
module seg_display_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] hex_in,
  input  logic [10:0] cnt_i,
  input  logic [10:0] cnt_r,
  input  logic [10:0] cnt_j,
  input  logic [10:0] cnt_clk,
  input  logic [2:0]  sel,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_CONV    = 2'd2;
  localparam logic [1:0] S_LOAD    = 2'd3;

  logic [DW-1:0] div_cnt;
  logic [2:0]    digit_idx;
  logic [31:0]   disp_buf;
  logic [1:0]    state;
  logic [10:0]   bin_sr;
  logic [15:0]   bcd;
  logic [15:0]   bcd_adj;
  logic [3:0]    iter;
  logic          cnt_src;
  logic [10:0]   src_cnt;
  logic [3:0]    nib;
  logic [6:0]    seg_next;
  logic [7:0]    an_next;
  logic          tick;
  logic          frame_wrap;

  assign tick       = (div_cnt == DIV_LAST);
  assign frame_wrap = tick && (digit_idx == 3'd7);
  assign busy       = (state == S_CONV);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt   <= '0;
      digit_idx <= 3'd0;
    end else if (tick) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      div_cnt   <= div_cnt + DW'(1);
    end
  end

  always_comb begin
    src_cnt = 11'd0;
    case (sel)
      3'd1:    src_cnt = cnt_clk;
      3'd2:    src_cnt = cnt_i;
      3'd3:    src_cnt = cnt_r;
      3'd4:    src_cnt = cnt_j;
      default: src_cnt = 11'd0;
    endcase
  end

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      disp_buf <= 32'h0;
      bin_sr   <= 11'd0;
      bcd      <= 16'h0;
      iter     <= 4'd0;
      cnt_src  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_wrap && !freeze) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (sel == 3'd0) begin
            disp_buf <= hex_in;
            cnt_src  <= 1'b0;
            state    <= S_IDLE;
          end else if (sel > 3'd4) begin
            disp_buf <= 32'h0;
            cnt_src  <= 1'b0;
            state    <= S_IDLE;
          end else begin
            bin_sr <= src_cnt;
            bcd    <= 16'h0;
            iter   <= 4'd0;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
          iter          <= iter + 4'd1;
          if (iter == 4'd10) state <= S_LOAD;
        end
        S_LOAD: begin
          disp_buf <= {16'h0, bcd};
          cnt_src  <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign nib = disp_buf[{digit_idx, 2'b00} +: 4];

  always_comb begin
    seg_next = 7'h40;
    case (nib)
      4'h0: seg_next = 7'h40;
      4'h1: seg_next = 7'h79;
      4'h2: seg_next = 7'h24;
      4'h3: seg_next = 7'h30;
      4'h4: seg_next = 7'h19;
      4'h5: seg_next = 7'h12;
      4'h6: seg_next = 7'h02;
      4'h7: seg_next = 7'h78;
      4'h8: seg_next = 7'h00;
      4'h9: seg_next = 7'h10;
      4'hA: seg_next = 7'h08;
      4'hB: seg_next = 7'h03;
      4'hC: seg_next = 7'h46;
      4'hD: seg_next = 7'h21;
      4'hE: seg_next = 7'h06;
      4'hF: seg_next = 7'h0E;
      default: seg_next = 7'h40;
    endcase
  end

  always_comb begin
    an_next = ~(8'd1 << digit_idx);
`ifdef LEADING_ZERO_BLANK_EN
    if ((digit_idx != 3'd0) && ((disp_buf >> {digit_idx, 2'b00}) == 32'h0)) an_next = 8'hFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= 8'hFE;
      seg <= 7'h40;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= !(cnt_src && (digit_idx == 3'd4));
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb/tb_seg_display_scanner.sv - self-checking bench for seg_display_scanner (SCAN_DIV=16)
module tb_seg_display_scanner;

  localparam int DIV   = 16;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] hex_in = 32'h0;
  logic [10:0] cnt_i = 11'd0, cnt_r = 11'd0, cnt_j = 11'd0, cnt_clk = 11'd0;
  logic [2:0]  sel = 3'd0;
  logic        freeze = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  seg_display_scanner #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in),
    .cnt_i(cnt_i), .cnt_r(cnt_r), .cnt_j(cnt_j), .cnt_clk(cnt_clk),
    .sel(sel), .freeze(freeze), .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int failures = 0;
  int ec = 0;
  int busy_total = 0;
  int busy_rise_ec = -1;
  logic busy_q = 1'b0;

  // Edges since reset release; all scan timing is derived from this count.
  always @(posedge clk) ec <= reset ? ec + 1 : 0;

  always @(negedge clk) begin
    if (busy) busy_total++;
    if (busy && !busy_q) busy_rise_ec = ec;
    busy_q = busy;
  end

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] hex;
    logic [10:0] cc, ci, cr, cj;
    logic        frz;
    logic [31:0] exp_buf;
    logic        exp_cnt;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] model_buf;
  logic        model_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic goto_edge(input int n);
    int guard;
    guard = 0;
    while (ec < n) begin
      @(negedge clk);
      guard++;
      if (guard > 4 * FRAME) begin
        $display("FAIL goto_edge timeout: ec=%0d target=%0d", ec, n);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
      end
    end
  endtask

  function automatic logic [4:0] undecode(input logic [6:0] s);
    for (int v = 0; v < 16; v++) if (SEG_TAB[v] == s) return {1'b1, 4'(v)};
    return 5'h0;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    return {16'h0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] model_value(input logic [2:0] s, input logic [31:0] h,
                                              input logic [10:0] cc, ci, cr, cj);
    case (s)
      3'd0: return h;
      3'd1: return to_bcd(int'(cc));
      3'd2: return to_bcd(int'(ci));
      3'd3: return to_bcd(int'(cr));
      3'd4: return to_bcd(int'(cj));
      default: return 32'h0;
    endcase
  endfunction

  // Apply inputs before the next frame wrap, then read back every digit slot of the following frame.
  task automatic run_frame(input string name, input vec_t v);
    int wrap, b0, exp_busy;
    logic [4:0]  u;
    logic [31:0] obs_val;
    logic        obs_ok;
    logic [63:0] obs_an, exp_an;
    logic [7:0]  obs_dp, exp_dp;
    b0 = busy_total;
    sel = v.sel; hex_in = v.hex; cnt_clk = v.cc; cnt_i = v.ci; cnt_r = v.cr; cnt_j = v.cj;
    freeze = v.frz;
    exp_busy = (!v.frz && v.sel >= 3'd1 && v.sel <= 3'd4) ? 11 : 0;
    wrap = ((ec + FRAME) / FRAME) * FRAME;
    obs_ok = 1'b1;
    for (int d = 0; d < 8; d++) begin
      goto_edge(wrap + DIV * d + DIV - 1);
      u = undecode(seg);
      obs_val[4*d +: 4] = u[3:0];
      obs_ok &= u[4];
      obs_an[8*d +: 8] = an;
      obs_dp[d] = dp;
      exp_an[8*d +: 8] = ~(8'd1 << d);
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && (v.exp_buf >> (4 * d)) == 32'h0) exp_an[8*d +: 8] = 8'hFF;
`endif
      exp_dp[d] = !(v.exp_cnt && d == 4);
    end
    check($sformatf("%s digits", name), {31'h0, obs_ok, obs_val}, {31'h0, 1'b1, v.exp_buf});
    check($sformatf("%s an", name), obs_an, exp_an);
    check($sformatf("%s dp", name), {56'h0, obs_dp}, {56'h0, exp_dp});
    check($sformatf("%s busy_cycles", name), 64'(busy_total - b0), 64'(exp_busy));
    if (exp_busy != 0) check($sformatf("%s busy_start", name), 64'(busy_rise_ec - wrap), 64'd1);
  endtask

  function automatic vec_t mk(input logic [2:0] s, input logic [31:0] h, input logic [10:0] cc, ci, cr, cj,
                              input logic f, input logic [31:0] eb, input logic ecnt);
    vec_t v;
    v.sel = s; v.hex = h; v.cc = cc; v.ci = ci; v.cr = cr; v.cj = cj; v.frz = f;
    v.exp_buf = eb; v.exp_cnt = ecnt;
    return v;
  endfunction

  initial begin
    vec_t rv;
    int wrap;
    vecs[0]  = mk(3'd0, 32'h1234ABCD, 11'd5,    11'd6,   11'd7, 11'd8,  1'b0, 32'h1234ABCD, 1'b0);
    vecs[1]  = mk(3'd1, 32'h55555555, 11'd2047, 11'd6,   11'd7, 11'd8,  1'b0, 32'h00002047, 1'b1);
    vecs[2]  = mk(3'd0, 32'h0000000F, 11'd5,    11'd6,   11'd7, 11'd8,  1'b0, 32'h0000000F, 1'b0);
    vecs[3]  = mk(3'd0, 32'hFFFFFFFF, 11'd5,    11'd6,   11'd7, 11'd8,  1'b1, 32'h0000000F, 1'b0);
    vecs[4]  = mk(3'd0, 32'hFFFFFFFF, 11'd5,    11'd6,   11'd7, 11'd8,  1'b1, 32'h0000000F, 1'b0);
    vecs[5]  = mk(3'd1, 32'hFFFFFFFF, 11'd5,    11'd6,   11'd7, 11'd8,  1'b1, 32'h0000000F, 1'b0);
    vecs[6]  = mk(3'd0, 32'hFFFFFFFF, 11'd5,    11'd6,   11'd7, 11'd8,  1'b0, 32'hFFFFFFFF, 1'b0);
    vecs[7]  = mk(3'd6, 32'hFFFFFFFF, 11'd5,    11'd6,   11'd7, 11'd8,  1'b0, 32'h00000000, 1'b0);
    vecs[8]  = mk(3'd3, 32'h87654321, 11'd5,    11'd6,   11'd0, 11'd8,  1'b0, 32'h00000000, 1'b1);
    vecs[9]  = mk(3'd0, 32'h12345678, 11'd5,    11'd6,   11'd0, 11'd8,  1'b1, 32'h00000000, 1'b1);
    vecs[10] = mk(3'd4, 32'h12345678, 11'd5,    11'd6,   11'd0, 11'd10, 1'b0, 32'h00000010, 1'b1);
    vecs[11] = mk(3'd7, 32'hDEADBEEF, 11'd5,    11'd6,   11'd0, 11'd10, 1'b0, 32'h00000000, 1'b0);
    vecs[12] = mk(3'd5, 32'hDEADBEEF, 11'd5,    11'd6,   11'd0, 11'd10, 1'b0, 32'h00000000, 1'b0);

    repeat (3) @(negedge clk);
    check("reset an", 64'(an), 64'hFE);
    check("reset seg", 64'(seg), 64'h40);
    check("reset dp", 64'(dp), 64'h1);
    check("reset busy", 64'(busy), 64'h0);
    reset = 1'b1;
    goto_edge(DIV);
    check("first slot an", 64'(an), 64'hFE);
    goto_edge(DIV + 1);
`ifdef LEADING_ZERO_BLANK_EN
    check("second slot an", 64'(an), 64'hFF);
`else
    check("second slot an", 64'(an), 64'hFD);
`endif

    for (int i = 0; i < 13; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Reset during the fifth conversion cycle discards the conversion.
    sel = 3'd2; cnt_i = 11'd999; freeze = 1'b0;
    wrap = ((ec + FRAME) / FRAME) * FRAME;
    goto_edge(wrap + 5);
    check("midconv busy before reset", 64'(busy), 64'h1);
    reset = 1'b0;
    @(negedge clk);
    check("midconv busy", 64'(busy), 64'h0);
    check("midconv an", 64'(an), 64'hFE);
    check("midconv seg", 64'(seg), 64'h40);
    check("midconv dp", 64'(dp), 64'h1);
    reset = 1'b1;
    run_frame("after_reset", mk(3'd2, 32'h0, 11'd0, 11'd999, 11'd0, 11'd0, 1'b0, 32'h00000999, 1'b1));

    model_buf = 32'h00000999;
    model_cnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rv.sel = 3'($urandom_range(0, 7));
      rv.hex = $urandom;
      rv.cc  = 11'($urandom);
      rv.ci  = 11'($urandom);
      rv.cr  = 11'($urandom);
      rv.cj  = 11'($urandom);
      rv.frz = ($urandom_range(0, 3) == 0);
      if (!rv.frz) begin
        model_buf = model_value(rv.sel, rv.hex, rv.cc, rv.ci, rv.cr, rv.cj);
        model_cnt = (rv.sel >= 3'd1 && rv.sel <= 3'd4);
      end
      rv.exp_buf = model_buf;
      rv.exp_cnt = model_cnt;
      run_frame($sformatf("rand%0d", i), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
